// File: rtl/pipe_mem_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_mem_pkg : shared types for the data-memory arbiter               |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_mem_pkg;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned IO_BIT_DEF = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CPU_RD = 2'd1,
      ST_DMA_RD = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_e;

endpackage

`default_nettype wire

// File: rtl/dmem_starve_counter.sv
// +----------------------------------------------------------------------+
// | dmem_starve_counter : saturating count of consecutive DMA losses      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_starve_counter #(
   parameter int unsigned LIMIT = 4,
   localparam int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic inc_i,
   input  logic clr_i,
   output logic limit_hit_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign limit_hit_o = (cnt_q == CNT_W'(LIMIT));

   // Clear wins over increment; the count sticks at LIMIT until cleared.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !limit_hit_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pipe_dmem_arbiter.sv
// +----------------------------------------------------------------------+
// | pipe_dmem_arbiter : shares the data RAM between MEM stage and DMA     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_dmem_arbiter
   import pipe_mem_pkg::*;
#(
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned IO_BIT       = IO_BIT_DEF,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [31:0]       cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   output logic              cpu_io_o,
   input  logic              dma_req_i,
   input  logic              dma_we_i,
   input  logic [ADDR_W-1:0] dma_addr_i,
   input  logic [DATA_W-1:0] dma_wdata_i,
   output logic              dma_gnt_o,
   output logic              dma_rvalid_o,
   output logic [DATA_W-1:0] dma_rdata_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   output logic              ram_we_o,
   input  logic [DATA_W-1:0] ram_rdata_i
);

   state_e state_q;
   state_e state_d;
   owner_e owner;
   logic   idle;
   logic   cpu_mem;
   logic   starve_hit;
   logic   starve_inc;
   logic   starve_clr;
   logic   unused_addr;

   assign unused_addr = ^cpu_addr_i;
   assign idle        = (state_q == ST_IDLE);
   assign cpu_mem     = cpu_req_i & ~cpu_addr_i[IO_BIT];

   // Outputs are forced quiet while reset is held, so the slot is never granted.
   always_comb begin
      owner = OWN_NONE;
      if (idle && !reset_i) begin
         if (dma_req_i && starve_hit) begin
            owner = OWN_DMA;
         end else if (cpu_mem) begin
            owner = OWN_CPU;
         end else if (dma_req_i) begin
            owner = OWN_DMA;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ram_addr_o   = '0;
      ram_wdata_o  = '0;
      ram_we_o     = 1'b0;
      dma_gnt_o    = 1'b0;
      dma_rvalid_o = 1'b0;
      dma_rdata_o  = '0;
      cpu_rdata_o  = '0;
      case (state_q)
         ST_IDLE: begin
            case (owner)
               OWN_CPU: begin
                  ram_addr_o  = cpu_addr_i[ADDR_W+1:2];
                  ram_wdata_o = cpu_wdata_i;
                  ram_we_o    = cpu_we_i;
                  if (!cpu_we_i) state_d = ST_CPU_RD;
               end
               OWN_DMA: begin
                  ram_addr_o  = dma_addr_i;
                  ram_wdata_o = dma_wdata_i;
                  ram_we_o    = dma_we_i;
                  dma_gnt_o   = 1'b1;
                  if (!dma_we_i) state_d = ST_DMA_RD;
               end
               default: ;
            endcase
         end
         ST_CPU_RD: begin
            cpu_rdata_o = ram_rdata_i;
            state_d     = ST_IDLE;
         end
         ST_DMA_RD: begin
            dma_rvalid_o = 1'b1;
            dma_rdata_o  = ram_rdata_i;
            state_d      = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cpu_stall_o = ~reset_i & cpu_mem
                      & ~((owner == OWN_CPU) & cpu_we_i)
                      & ~(state_q == ST_CPU_RD);
   assign cpu_io_o    = ~reset_i & cpu_req_i & cpu_addr_i[IO_BIT];

   // The loss count only moves in issue cycles; read-return cycles hold it.
   assign starve_inc = idle & dma_req_i & ~dma_gnt_o;
   assign starve_clr = idle & (dma_gnt_o | ~dma_req_i);

   dmem_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .inc_i       (starve_inc),
      .clr_i       (starve_clr),
      .limit_hit_o (starve_hit)
   );

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

`default_nettype wire
